// File: rtl/rpl_lock_responder.sv
// Resource-pool lock responder: grants up to NUM_UNITS interchangeable units to
// requesting ports, oldest issue ID first, and holds each grant until released.
module rpl_lock_responder #(
    parameter int NUM_PORTS = 4,
    parameter int NUM_UNITS = 2,
    parameter int ID_WIDTH  = 16,
    localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1,
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
    localparam int CW = $clog2(NUM_UNITS) + 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush,
    input  logic [NUM_PORTS-1:0]               req_valid,
    input  logic [NUM_PORTS-1:0][ID_WIDTH-1:0] req_id,
    output logic [NUM_PORTS-1:0]               grant,
    output logic [NUM_PORTS-1:0][UW-1:0]       grant_unit,
    output logic [NUM_UNITS-1:0]               unit_busy,
    output logic [NUM_UNITS-1:0][PW-1:0]       unit_owner,
    output logic [CW-1:0]                      busy_count
);

    localparam int SW = ((PW > UW) ? PW : UW) + 1;

    logic [NUM_UNITS-1:0]          busy_q, busy_d;
    logic [NUM_UNITS-1:0][PW-1:0]  owner_q, owner_d;
    logic [NUM_PORTS-1:0]          grant_q, grant_d;
    logic [NUM_PORTS-1:0][UW-1:0]  gunit_q, gunit_d;
    logic [CW-1:0]                 count_q, count_d;

    logic [NUM_UNITS-1:0]          keep;
    logic [NUM_PORTS-1:0]          holds;
    logic [NUM_PORTS-1:0]          cand;
    logic [NUM_PORTS-1:0][SW-1:0]  rank;
    logic [ID_WIDTH-1:0]           diff;
    logic [SW-1:0]                 slot;

    always_comb begin : retain_c
        keep  = '0;
        holds = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            keep[u] = busy_q[u] & req_valid[owner_q[u]];
            if (keep[u]) begin
                holds[owner_q[u]] = 1'b1;
            end
        end
        cand = req_valid & ~holds;
    end

    // rank[p] = number of waiting candidates older than p (wrap-aware, ties to lower port)
    always_comb begin : rank_c
        rank = '0;
        diff = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int q = 0; q < NUM_PORTS; q++) begin
                if (q != p && cand[q]) begin
                    diff = req_id[q] - req_id[p];
                    if (diff[ID_WIDTH-1] || (diff == '0 && q < p)) begin
                        rank[p] = rank[p] + SW'(1);
                    end
                end
            end
        end
    end

    // The k-th free unit (ascending index) goes to the candidate of rank k.
    always_comb begin : alloc_c
        busy_d  = '0;
        owner_d = '0;
        grant_d = '0;
        gunit_d = '0;
        count_d = '0;
        slot    = '0;
        if (!flush) begin
            for (int u = 0; u < NUM_UNITS; u++) begin
                if (keep[u]) begin
                    busy_d[u]  = 1'b1;
                    owner_d[u] = owner_q[u];
                end else begin
                    for (int p = 0; p < NUM_PORTS; p++) begin
                        if (cand[p] && rank[p] == slot) begin
                            busy_d[u]  = 1'b1;
                            owner_d[u] = PW'(p);
                        end
                    end
                    slot = slot + SW'(1);
                end
            end
        end
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (busy_d[u]) begin
                grant_d[owner_d[u]] = 1'b1;
                gunit_d[owner_d[u]] = UW'(u);
                count_d             = count_d + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q  <= '0;
            owner_q <= '0;
            grant_q <= '0;
            gunit_q <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
            gunit_q <= gunit_d;
            count_q <= count_d;
        end
    end

    assign grant      = grant_q;
    assign grant_unit = gunit_q;
    assign unit_busy  = busy_q;
    assign unit_owner = owner_q;
    assign busy_count = count_q;

endmodule

// File: doc/rpl_lock_responder.md
Name: rpl_lock_responder

Overview:
- Responder end of the resource-pool-lock handshake that SICs drive toward shared execution resources such as the ALU pool and data memory.
- Receives per-port lock requests tagged with issue IDs and grants up to NUM_UNITS identical units, oldest issue ID first.
- Holds each grant until the requester drops its request, then frees the unit.
- Sits between the SIC array and a resource array; it also drives the unit-select index that the resource datapath muxes on.

Parameters:
- NUM_PORTS, 4, number of requesting SIC ports.
- NUM_UNITS, 2, number of interchangeable resource units.
- ID_WIDTH, 16, issue-ID width; IDs wrap modulo 2^ID_WIDTH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  rollback: synchronously drop all locks.
- req_valid  in  NUM_PORTS  per-port lock request; held high for the whole lock lifetime.
- req_id  in  NUM_PORTS x ID_WIDTH  issue ID of each requester.
- grant  out  NUM_PORTS  registered; high while the port owns a unit.
- grant_unit  out  NUM_PORTS x clog2(NUM_UNITS)  unit index owned by the port; valid only when grant is high.
- unit_busy  out  NUM_UNITS  registered; unit currently owned.
- unit_owner  out  NUM_UNITS x clog2(NUM_PORTS)  owning port of each unit; valid when unit_busy is high.
- busy_count  out  clog2(NUM_UNITS)+1  number of busy units.

Behaviour:
- Reset, asynchronous, active-high: grant=0, grant_unit=0, unit_busy=0, unit_owner=0, busy_count=0. Reset asserted mid-lock drops every lock immediately, with no release cycle.
- State per unit: FREE or OWNED(port). All outputs are registered from this state.
- Every rising edge, with rst low and flush low, the next state is computed as follows:
  - Retain: an OWNED(p) unit stays owned if req_valid[p]=1.
  - Release: an OWNED(p) unit becomes FREE if req_valid[p]=0. A unit released at an edge is reallocatable at that same edge.
  - Allocate: candidates are ports with req_valid=1 that retain no unit.
  - Candidates are sorted oldest first and take FREE units in ascending unit index until units or candidates run out.
  - Age rule: a older than b iff the signed ID_WIDTH-bit value (a-b) is < 0. Equal IDs are broken by lower port index first.
- Latency: request sampled at edge t → grant high in the cycle after t (1 cycle). Release sampled at edge t → grant low in the cycle after t.
- No preemption. A younger owner keeps its unit even when an older requester is waiting.
- req_id changes on a granted port are ignored until that port releases.
- A port owns at most one unit.
- Pool full: excess requesters stay ungranted. They are re-evaluated every edge with no queue state, so age order is recomputed each cycle.
- flush=1 at an edge: all units go FREE, all grants go low, and no allocation happens that edge. Requests still high after flush are allocated at the next edge. flush takes priority over both release and allocate.
- busy_count always equals popcount(unit_busy).
- Invariants, asserted in the bench:
  - grant[p] ⇔ some unit has unit_busy=1 and unit_owner=p.
  - No two busy units share an owner.
  - grant never rises on a port whose req_valid was 0 at the previous edge.

Test Plan:
1. Reset release, idle: no requests for 5 cycles → grant=0000, unit_busy=00, busy_count=0.
2. Single grant/release:
   - Port0 req id=5 at edge 1 → grant[0]=1 and grant_unit[0]=0 from cycle 2.
   - Drop req at edge 4 → grant[0]=0 and unit_busy[0]=0 from cycle 5.
3. Age arbitration with pool full: ports 0..3 request ids 40, 10, 30, 20 at the same edge.
   - Port1 gets unit0, port3 gets unit1; ports 0 and 2 stay low; busy_count=2.
4. Wrap-around age plus same-edge reuse:
   - Port0 id=0xFFFE owns unit0; port1 id=0x0001 and port2 id=0x0003 are waiting.
   - Port0 releases → at that edge unit0 goes to port1 (0xFFFE wrap ignored, 0x0001 older than 0x0003); port2 still waits.
5. No preemption: port2 id=50 owns both-free-pool unit0, port3 id=60 owns unit1, then port0 requests id=1 → port0 stays ungranted until port2 drops, then takes unit0 the next cycle.
6. Flush and async reset:
   - With 2 units owned and requests held, flush for 1 edge → all grants 0 for one cycle, re-granted by age the following cycle.
   - Assert rst between edges → all outputs 0 immediately.
